// File: rtl/foo_sched.sv
// Round-robin front end that shares one foo model instance among NUM_REQ
// requesters and returns each result tagged with its requester index.
module foo_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 1,
  parameter int PIPELINED = 0,
  localparam int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         foo_a,
  input  logic [DATA_W-1:0]         foo_x,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  logic [ID_W-1:0]    rr_ptr;
  logic [LATENCY-1:0] fl_vld;
  logic [ID_W-1:0]    fl_id [LATENCY];

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [ID_W:0]      idx;
  logic [DATA_W-1:0]  gnt_data;
  logic               issue_ok;
  logic               hs;

  assign busy     = |fl_vld;
  assign issue_ok = enable && ((PIPELINED != 0) || !busy);

  // Handshake: requester i transfers when req_valid[i] & req_ready[i] at a
  // rising edge; req_valid may drop without a transfer, and rsp_valid is a
  // one-cycle strobe with no backpressure.
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && req_valid[idx[ID_W-1:0]]) begin
        gnt_any                  = 1'b1;
        gnt_id                   = idx[ID_W-1:0];
        grant[idx[ID_W-1:0]]     = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign req_ready = (rst_n && issue_ok) ? grant : '0;
  assign hs        = rst_n && issue_ok && gnt_any;

  // In-flight tags shift every cycle; the one leaving the last stage owns foo_x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      foo_a     <= '0;
      fl_vld    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      for (int s = 0; s < LATENCY; s++) fl_id[s] <= '0;
    end else begin
      fl_vld[0] <= hs;
      fl_id[0]  <= gnt_id;
      for (int s = 1; s < LATENCY; s++) begin
        fl_vld[s] <= fl_vld[s-1];
        fl_id[s]  <= fl_id[s-1];
      end
      rsp_valid <= fl_vld[LATENCY-1];
      if (fl_vld[LATENCY-1]) begin
        rsp_id   <= fl_id[LATENCY-1];
        rsp_data <= foo_x;
      end
      if (hs) begin
        foo_a  <= gnt_data;
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

endmodule
